load_store_unit: RTL and testbench

- Initiator-side master for the word-addressed data memory.
- Sits between the CPU's memory stage and the data memory. Accepts one load/store request at a time over a valid/ready handshake.
- Drives the memory's index/write-data/write-enable port. Extracts and sign- or zero-extends byte and halfword loads.
- Performs read-modify-write for byte and halfword stores, since the memory only writes whole words.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory port bundle for the load/store unit.
// master = the unit itself, slave = CPU memory stage plus data memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_idx;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_idx, mem_write_data, mem_write_enable
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_idx, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: word-memory master with sub-word extract and RMW stores.
// Define LSU_MISALIGN_FAULT_EN to fault misaligned accesses instead of aligning them.
module load_store_unit #(
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic clk,
    input  logic reset,
    load_store_unit_if.master bus
);

    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, FAULT} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept;
    logic        legal;
    logic        out_of_range;
    logic        fault;
    logic [31:0] addr_al;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] merge_val;

    always_comb begin
        accept = bus.req_valid & (state_q == IDLE);
        if (bus.req_write) begin
            legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010,
                                           3'b100, 3'b101};
        end
        out_of_range = (bus.req_addr >> MEM_ADDR_BITS) != 32'd0;
        addr_al = bus.req_addr;
`ifdef LSU_MISALIGN_FAULT_EN
        fault = ~legal | out_of_range
              | ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0])
              | ((bus.req_funct3[1:0] == 2'b10) & (|bus.req_addr[1:0]));
`else
        // Misaligned accesses are silently rounded down to natural alignment.
        fault = ~legal | out_of_range;
        if (bus.req_funct3[1:0] == 2'b01) begin
            addr_al[0] = 1'b0;
        end else if (bus.req_funct3[1:0] == 2'b10) begin
            addr_al[1:0] = 2'b00;
        end
`endif
    end

    always_comb begin
        ld_byte = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? bus.mem_read_data[31:16]
                            : bus.mem_read_data[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_val = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
            default: ld_val = bus.mem_read_data;
        endcase
        merge_val = bus.mem_read_data;
        if (funct3_q[1:0] == 2'b00) begin
            merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = addr_al;
                    funct3_d = bus.req_funct3;
                    wdata_d  = bus.req_wdata[15:0];
                    // SW writes straight from here; SB/SH overwrite it in MERGE.
                    merge_d  = bus.req_wdata;
                    if (fault) begin
                        state_d = FAULT;
                    end else if (!bus.req_write) begin
                        state_d = LOAD;
                    end else if (bus.req_funct3[1:0] == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            LOAD: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_val;
                state_d      = IDLE;
            end
            MERGE: begin
                merge_d = merge_val;
                state_d = WRITE;
            end
            WRITE: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'd0;
                state_d      = IDLE;
            end
            FAULT: begin
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b1;
                resp_rdata_d = 32'd0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            funct3_q     <= 3'd0;
            wdata_q      <= 16'd0;
            merge_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        bus.req_ready        = (state_q == IDLE);
        bus.resp_valid       = resp_valid_q;
        bus.resp_fault       = resp_fault_q;
        bus.resp_rdata       = resp_rdata_q;
        bus.mem_idx          = (state_q inside {LOAD, MERGE, WRITE})
                             ? {addr_q[31:2], 2'b00} : 32'd0;
        bus.mem_write_enable = (state_q == WRITE) & ~reset;
        bus.mem_write_data   = bus.mem_write_enable ? merge_q : 32'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random ops vs a memory model.
// Follows LSU_MISALIGN_FAULT_EN the same way as the design build.
module tb_load_store_unit;
    localparam int MAB = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   wr_count = 0;
    logic [31:0] last_wr_idx = 32'd0;
    logic [31:0] last_wr_data = 32'd0;
    logic [31:0] last_rdata;
    logic        last_fault;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];

    load_store_unit_if bus ();

    load_store_unit #(.MEM_ADDR_BITS(MAB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_read_data = mem[bus.mem_idx[9:2]];

    always @(posedge clk) begin
        if (bus.mem_write_enable) begin
            mem[bus.mem_idx[9:2]] <= bus.mem_write_data;
            wr_count              <= wr_count + 1;
            last_wr_idx           <= bus.mem_idx;
            last_wr_data          <= bus.mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: access rules in plain arithmetic; stores update ref_mem.
    task automatic model(input bit w, input logic [2:0] f3,
                         input logic [31:0] a_in, input logic [31:0] wd,
                         output bit flt, output logic [31:0] rd,
                         output int lat, output bit wr);
        longint unsigned a, sz, off, word, val, lane;
        bit legal;
        a     = a_in;
        sz    = 64'd1 << f3[1:0];
        legal = w ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        flt   = !legal || (a >= (64'd1 << MAB));
`ifdef LSU_MISALIGN_FAULT_EN
        if (legal && (a % sz) != 0) flt = 1'b1;
`else
        if (legal) a = a - (a % sz);
`endif
        rd  = 32'd0;
        wr  = 1'b0;
        lat = 2;
        if (flt) return;
        word = 64'(ref_mem[int'(a / 4)]);
        off  = (a % 4) * 8;
        lane = (64'd1 << (8 * sz)) - 1;
        if (!w) begin
            val = (word >> off) & lane;
            if (f3 < 4 && sz < 4 && val >= (lane + 1) / 2) val = val | ~lane;
            rd = val[31:0];
        end else begin
            val = (word & ~(lane << off)) | ((64'(wd) & lane) << off);
            ref_mem[int'(a / 4)] = val[31:0];
            wr  = 1'b1;
            lat = (sz == 4) ? 2 : 3;
        end
    endtask

    task automatic mem_compare(input string tag);
        int diff = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diff++;
        check(tag, 32'(diff), 32'd0);
    endtask

    task automatic lsu_op(input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        bit eflt, ewr;
        logic [31:0] erd;
        int elat, lat, n, wc0;
        model(w, f3, a, wd, eflt, erd, elat, ewr);
        @(negedge clk);
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready", 32'(bus.req_ready), 32'd1);
        wc0 = wr_count;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'(elat));
        check("fault", 32'(bus.resp_fault), 32'(eflt));
        check("rdata", bus.resp_rdata, erd);
        check("strobes", 32'(wr_count - wc0), 32'(ewr));
        mem_compare("memory");
        last_rdata = bus.resp_rdata;
        last_fault = bus.resp_fault;
        @(negedge clk);
        check("pulse", 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit eflt, ewr;
        logic [31:0] erd_a, erd_b, old;
        int elat, wc0;
        bit w;
        logic [2:0] f3;
        logic [31:0] a;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mem_we", 32'(bus.mem_write_enable), 32'd0);
        check("rst_mem_idx", bus.mem_idx, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) lsu_op(1'b1, 3'b010, 32'(i * 4), $urandom);

        lsu_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_idx", last_wr_idx, 32'h10);
        check("sw_data", last_wr_data, 32'hDEADBEEF);

        lsu_op(1'b1, 3'b010, 32'h10, 32'h80817F01);
        lsu_op(1'b0, 3'b000, 32'h11, 32'd0);
        check("lb_11", last_rdata, 32'h0000007F);
        lsu_op(1'b0, 3'b000, 32'h13, 32'd0);
        check("lb_13", last_rdata, 32'hFFFFFF80);
        lsu_op(1'b0, 3'b100, 32'h13, 32'd0);
        check("lbu_13", last_rdata, 32'h00000080);
        lsu_op(1'b0, 3'b001, 32'h12, 32'd0);
        check("lh_12", last_rdata, 32'hFFFF8081);
        lsu_op(1'b0, 3'b101, 32'h12, 32'd0);
        check("lhu_12", last_rdata, 32'h00008081);

        lsu_op(1'b1, 3'b010, 32'h20, 32'h11223344);
        lsu_op(1'b1, 3'b000, 32'h22, 32'h000000AA);
        check("sb_word", mem[8], 32'h11AA3344);
        lsu_op(1'b1, 3'b001, 32'h20, 32'h00005566);
        check("sh_word", mem[8], 32'h11AA5566);

        lsu_op(1'b0, 3'b010, 32'h06, 32'd0);
`ifdef LSU_MISALIGN_FAULT_EN
        check("lw_mis_fault", 32'(last_fault), 32'd1);
`else
        check("lw_mis_data", last_rdata, mem[1]);
`endif
        lsu_op(1'b1, 3'b001, 32'h21, 32'h0000BEEF);
`ifdef LSU_MISALIGN_FAULT_EN
        check("sh_mis_word", mem[8], 32'h11AA5566);
`else
        check("sh_mis_word", mem[8], 32'h11AABEEF);
`endif

        lsu_op(1'b0, 3'b011, 32'h10, 32'd0);
        check("ld_f3_011", 32'(last_fault), 32'd1);
        lsu_op(1'b1, 3'b010, 32'h400, 32'h12345678);
        check("sw_oor", 32'(last_fault), 32'd1);

        // Reset while the SW to 0x30 is in its write cycle.
        old = ref_mem[12];
        @(negedge clk);
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = ~old;
        bus.req_valid  = 1'b1;
        wc0 = wr_count;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_wr_we_before", 32'(bus.mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_wr_we_gated", 32'(bus.mem_write_enable), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_wr_no_resp", 32'(bus.resp_valid), 32'd0);
        check("rst_wr_ready", 32'(bus.req_ready), 32'd1);
        check("rst_wr_word", mem[12], old);
        check("rst_wr_strobes", 32'(wr_count - wc0), 32'd0);
        @(negedge clk);
        check("rst_wr_no_resp2", 32'(bus.resp_valid), 32'd0);

        // Back-to-back loads held valid: accepted on consecutive IDLE cycles.
        model(1'b0, 3'b010, 32'h10, 32'd0, eflt, erd_a, elat, ewr);
        model(1'b0, 3'b010, 32'h20, 32'd0, eflt, erd_b, elat, ewr);
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_addr = 32'h20;
        check("b2b_busy", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_resp_a", 32'(bus.resp_valid), 32'd1);
        check("b2b_data_a", bus.resp_rdata, erd_a);
        check("b2b_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_gap", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_resp_b", 32'(bus.resp_valid), 32'd1);
        check("b2b_data_b", bus.resp_rdata, erd_b);

        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom);
            a  = (($urandom % 8) == 0) ? (32'h400 | $urandom)
                                       : 32'($urandom_range(0, 255));
            lsu_op(w, f3, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
